rob_commit: RTL and testbench

Reorder buffer with in-order retirement. This block is the consumer end of the decode stage's ROB writes. Decode allocates entries at the tail (opcode and destination register) and gets back the ROB tag used for renaming. The common data bus (CDB) marks entries complete by tag. This block retires the head entry, one per cycle, to the register file and emits the tag so the rename table can clear stale mappings.

---
 rtl/rob_commit_if.sv | 43 ++++
 rtl/rob_commit.sv | 143 ++++++++++++++
 tb/tb_rob_commit.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_if.sv
// Handshake bundle between decode/CDB producers and the reorder buffer.
// The master drives allocations and CDB broadcasts and observes the retire side.
// The slave is the ROB itself.
interface rob_commit_if #(
    parameter int PTR_W  = 3,
    parameter int REG_W  = 4,
    parameter int DATA_W = 16
);
    logic              alloc_valid;
    logic [3:0]        alloc_opcode;
    logic [REG_W-1:0]  alloc_dest;
    logic              alloc_ready;
    logic [PTR_W-1:0]  alloc_tag;

    logic              cdb_valid;
    logic [PTR_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              commit_valid;
    logic [REG_W-1:0]  commit_reg;
    logic [DATA_W-1:0] commit_data;
    logic [PTR_W-1:0]  commit_tag;

    logic [PTR_W:0]    rob_count;
    logic              rob_full;
    logic              rob_empty;

    modport master (
        output alloc_valid, alloc_opcode, alloc_dest,
        output cdb_valid, cdb_tag, cdb_data,
        input  alloc_ready, alloc_tag,
        input  commit_valid, commit_reg, commit_data, commit_tag,
        input  rob_count, rob_full, rob_empty
    );

    modport slave (
        input  alloc_valid, alloc_opcode, alloc_dest,
        input  cdb_valid, cdb_tag, cdb_data,
        output alloc_ready, alloc_tag,
        output commit_valid, commit_reg, commit_data, commit_tag,
        output rob_count, rob_full, rob_empty
    );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer with in-order retirement.
// Entries are allocated at the tail and completed by tag from the CDB.
// The head entry retires once it is done, at most one entry per cycle.
// Full and empty are derived from the occupancy count, never from pointer equality.
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int REG_W  = 4,
    parameter int DATA_W = 16
) (
    input logic         clk,
    input logic         rst,
    rob_commit_if.slave rob_if
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [3:0]        opcode_q [DEPTH];
    logic [3:0]        opcode_d [DEPTH];
    logic [REG_W-1:0]  dest_q   [DEPTH];
    logic [REG_W-1:0]  dest_d   [DEPTH];
    logic [DATA_W-1:0] data_q   [DEPTH];
    logic [DATA_W-1:0] data_d   [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;

    logic              commit_valid_q, commit_valid_d;
    logic [REG_W-1:0]  commit_reg_q, commit_reg_d;
    logic [DATA_W-1:0] commit_data_q, commit_data_d;
    logic [PTR_W-1:0]  commit_tag_q, commit_tag_d;

    logic              full;
    logic              alloc_fire;
    logic              commit_fire;
    logic              wb_fire;

    assign full = (count_q == DEPTH_C);

    // Refusal is based on the current count, so a same-cycle commit cannot
    // open a slot for an allocation while the buffer is full.
    assign alloc_fire  = rob_if.alloc_valid && !full;
    assign commit_fire = busy_q[head_q] && done_q[head_q] && (count_q != '0);

    // A tail entry being allocated is never busy, so it would be ignored anyway;
    // the explicit term keeps "allocation wins" independent of that invariant.
    assign wb_fire = rob_if.cdb_valid
                  && busy_q[rob_if.cdb_tag]
                  && !done_q[rob_if.cdb_tag]
                  && !(alloc_fire && (rob_if.cdb_tag == tail_q));

    // Next-state for entry storage, pointers, count and the retire registers.
    always_comb begin
        busy_d         = busy_q;
        done_d         = done_q;
        opcode_d       = opcode_q;
        dest_d         = dest_q;
        data_d         = data_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_valid_d = 1'b0;
        commit_reg_d   = commit_reg_q;
        commit_data_d  = commit_data_q;
        commit_tag_d   = commit_tag_q;

        if (wb_fire) begin
            done_d[rob_if.cdb_tag] = 1'b1;
            data_d[rob_if.cdb_tag] = rob_if.cdb_data;
        end

        if (commit_fire) begin
            commit_valid_d = 1'b1;
            commit_reg_d   = dest_q[head_q];
            commit_data_d  = data_q[head_q];
            commit_tag_d   = head_q;
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + PTR_W'(1);
        end

        // Applied last so allocation overrides any same-cycle write to the tail slot.
        if (alloc_fire) begin
            busy_d[tail_q]   = 1'b1;
            done_d[tail_q]   = 1'b0;
            opcode_d[tail_q] = rob_if.alloc_opcode;
            dest_d[tail_q]   = rob_if.alloc_dest;
            tail_d           = tail_q + PTR_W'(1);
        end

        case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state and retire outputs; reset discards every in-flight entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_reg_q   <= '0;
            commit_data_q  <= '0;
            commit_tag_q   <= '0;
        end else begin
            busy_q         <= busy_d;
            done_q         <= done_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_reg_q   <= commit_reg_d;
            commit_data_q  <= commit_data_d;
            commit_tag_q   <= commit_tag_d;
        end
    end

    // Payload storage is only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        opcode_q <= opcode_d;
        dest_q   <= dest_d;
        data_q   <= data_d;
    end

    assign rob_if.alloc_ready  = !full;
    assign rob_if.alloc_tag    = tail_q;
    assign rob_if.commit_valid = commit_valid_q;
    assign rob_if.commit_reg   = commit_reg_q;
    assign rob_if.commit_data  = commit_data_q;
    assign rob_if.commit_tag   = commit_tag_q;
    assign rob_if.rob_count    = count_q;
    assign rob_if.rob_full     = full;
    assign rob_if.rob_empty    = (count_q == '0);

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus random traffic, all compared
// against an in-order queue model of the reorder buffer.
module tb_rob_commit;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rob_commit_if #(.PTR_W(3), .REG_W(4), .DATA_W(16)) rob_if ();

    rob_commit #(.DEPTH(8), .PTR_W(3), .REG_W(4), .DATA_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .rob_if (rob_if.slave)
    );

    // Reference model: the ROB is an ordered list of in-flight instructions,
    // oldest first. Tags are handed out sequentially modulo DEPTH.
    typedef struct {
        int          tag;
        logic [3:0]  dest;
        bit          done;
        logic [15:0] data;
    } ent_t;

    ent_t        rob_m[$];
    int          next_tag;
    bit          m_cv;
    logic [3:0]  m_reg;
    logic [15:0] m_data;
    int          m_tag;

    task automatic model_reset();
        rob_m.delete();
        next_tag = 0;
        m_cv     = 1'b0;
        m_reg    = '0;
        m_data   = '0;
        m_tag    = 0;
    endtask

    task automatic model_step(input bit av, input logic [3:0] dst,
                              input bit cv, input int ctag, input logic [15:0] cd);
        bit do_commit;
        bit do_alloc;
        do_commit = (rob_m.size() > 0) && rob_m[0].done;
        do_alloc  = av && (rob_m.size() < DEPTH);
        if (cv) begin
            foreach (rob_m[i]) begin
                if (rob_m[i].tag == ctag && !rob_m[i].done) begin
                    rob_m[i].done = 1'b1;
                    rob_m[i].data = cd;
                end
            end
        end
        m_cv = do_commit;
        if (do_commit) begin
            m_reg  = rob_m[0].dest;
            m_data = rob_m[0].data;
            m_tag  = rob_m[0].tag;
            void'(rob_m.pop_front());
        end
        if (do_alloc) begin
            rob_m.push_back('{tag: next_tag, dest: dst, done: 1'b0, data: 16'h0});
            next_tag = (next_tag + 1) % DEPTH;
        end
    endtask

    function automatic logic [33:0] obs_vec();
        return {rob_if.commit_valid, rob_if.commit_reg, rob_if.commit_data,
                rob_if.commit_tag, rob_if.rob_count, rob_if.rob_full,
                rob_if.rob_empty, rob_if.alloc_ready, rob_if.alloc_tag};
    endfunction

    function automatic logic [33:0] exp_vec();
        int n;
        n = rob_m.size();
        return {m_cv, m_reg, m_data, 3'(m_tag), 4'(n), (n == DEPTH), (n == 0),
                (n != DEPTH), 3'(next_tag)};
    endfunction

    // One clock: apply inputs, advance the model at the edge, settle after it.
    task automatic cyc(input bit av, input logic [3:0] dst, input bit cv,
                       input int ctag, input logic [15:0] cd);
        rob_if.alloc_valid  = av;
        rob_if.alloc_opcode = 4'($urandom_range(0, 15));
        rob_if.alloc_dest   = dst;
        rob_if.cdb_valid    = cv;
        rob_if.cdb_tag      = 3'(ctag);
        rob_if.cdb_data     = cd;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(av, dst, cv, ctag, cd);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 1'b0, 0, 16'h0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) idle();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < DEPTH; t++) cyc(1'b0, 4'h0, 1'b1, t, 16'($urandom));
        for (int i = 0; i < 10; i++) idle();
    endtask

    task automatic test_reset();
        rob_if.alloc_valid = 1'b0;
        rob_if.cdb_valid   = 1'b0;
        do_reset(2);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=%h", obs_vec(), exp_vec());
        end
        n_tests++;
        if ({rob_if.rob_empty, rob_if.alloc_ready, rob_if.alloc_tag, rob_if.rob_count,
             rob_if.commit_valid} !== {1'b1, 1'b1, 3'd0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=%b",
                     {rob_if.rob_empty, rob_if.alloc_ready, rob_if.alloc_tag,
                      rob_if.rob_count, rob_if.commit_valid}, 10'b11_000_0000_0);
        end
    endtask

    task automatic test_out_of_order();
        logic [3:0]  exp_reg  [3] = '{4'd1, 4'd2, 4'd3};
        logic [15:0] exp_data [3] = '{16'h0011, 16'h0022, 16'h00AA};
        int          seen = 0;
        do_reset(1);
        for (int i = 1; i <= 3; i++) cyc(1'b1, 4'(i), 1'b0, 0, 16'h0);
        cyc(1'b0, 4'h0, 1'b1, 2, 16'h00AA);
        cyc(1'b0, 4'h0, 1'b1, 0, 16'h0011);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) cyc(1'b0, 4'h0, 1'b1, 1, 16'h0022);
            else        idle();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ooo_cycle%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (rob_if.commit_valid === 1'b1) begin
                n_tests++;
                if (seen > 2 || {rob_if.commit_reg, rob_if.commit_data, rob_if.commit_tag}
                        !== {exp_reg[seen], exp_data[seen], 3'(seen)}) begin
                    n_fail++;
                    $display("FAIL ooo_commit%0d got=r%0d/%h/t%0d exp=r%0d/%h/t%0d", seen,
                             rob_if.commit_reg, rob_if.commit_data, rob_if.commit_tag,
                             exp_reg[seen % 3], exp_data[seen % 3], seen);
                end
                seen++;
            end
            // Three retirements must land on back-to-back cycles 0,1,2.
            n_tests++;
            if (rob_if.commit_valid !== (i < 3)) begin
                n_fail++;
                $display("FAIL ooo_back_to_back cycle%0d got=%b exp=%b", i,
                         rob_if.commit_valid, (i < 3));
            end
        end
        n_tests++;
        if (rob_if.rob_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL ooo_empty got=%b exp=1", rob_if.rob_empty);
        end
    endtask

    task automatic test_full();
        do_reset(1);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 4'($urandom), 1'b0, 0, 16'h0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL full_fill%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if ({rob_if.rob_full, rob_if.alloc_ready, rob_if.alloc_tag, rob_if.rob_count}
                !== {1'b1, 1'b0, 3'd0, 4'd8}) begin
            n_fail++;
            $display("FAIL full_flags got=%b exp=%b",
                     {rob_if.rob_full, rob_if.alloc_ready, rob_if.alloc_tag,
                      rob_if.rob_count}, 9'b1_0_000_1000);
        end
        cyc(1'b1, 4'hF, 1'b0, 0, 16'h0);
        n_tests++;
        if (rob_if.rob_count !== 4'd8 || rob_if.alloc_tag !== 3'd0) begin
            n_fail++;
            $display("FAIL full_ninth_alloc count=%0d tag=%0d exp count=8 tag=0",
                     rob_if.rob_count, rob_if.alloc_tag);
        end
        // Head completes; a commit and an alloc in the same full cycle: alloc refused.
        cyc(1'b0, 4'h0, 1'b1, 0, 16'h1357);
        cyc(1'b1, 4'h9, 1'b0, 0, 16'h0);
        n_tests++;
        if (rob_if.commit_valid !== 1'b1 || rob_if.rob_count !== 4'd7) begin
            n_fail++;
            $display("FAIL full_commit_refuses_alloc cv=%b count=%0d exp cv=1 count=7",
                     rob_if.commit_valid, rob_if.rob_count);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        do_reset(1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'(i + 4), 1'b0, 0, 16'h0);
        cyc(1'b0, 4'h0, 1'b1, 0, 16'h5A5A);
        cyc(1'b1, 4'hC, 1'b0, 0, 16'h0);
        n_tests++;
        if ({rob_if.commit_valid, rob_if.rob_count, rob_if.commit_tag, rob_if.alloc_tag,
             rob_if.commit_data} !== {1'b1, 4'd5, 3'd0, 3'd6, 16'h5A5A}) begin
            n_fail++;
            $display("FAIL simul_alloc_commit cv=%b count=%0d ctag=%0d atag=%0d data=%h exp 1/5/0/6/5a5a",
                     rob_if.commit_valid, rob_if.rob_count, rob_if.commit_tag,
                     rob_if.alloc_tag, rob_if.commit_data);
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [15:0] d;
        do_reset(1);
        for (int i = 0; i < 12; i++) begin
            d = 16'($urandom);
            cyc(1'b1, 4'(i), 1'b0, 0, 16'h0);
            cyc(1'b0, 4'h0, 1'b1, i % DEPTH, d);
            idle();
            n_tests++;
            if ({rob_if.commit_valid, rob_if.commit_tag, rob_if.commit_data, rob_if.commit_reg}
                    !== {1'b1, 3'(i % DEPTH), d, 4'(i)}) begin
                n_fail++;
                $display("FAIL wrap_seq%0d cv=%b tag=%0d data=%h reg=%0d exp 1/%0d/%h/%0d", i,
                         rob_if.commit_valid, rob_if.commit_tag, rob_if.commit_data,
                         rob_if.commit_reg, i % DEPTH, d, i);
            end
        end
    endtask

    task automatic test_edge_cases();
        do_reset(1);
        cyc(1'b1, 4'h1, 1'b0, 0, 16'h0);
        cyc(1'b1, 4'h2, 1'b0, 0, 16'h0);
        cyc(1'b0, 4'h0, 1'b1, 5, 16'hBEEF);
        idle();
        n_tests++;
        if (obs_vec() !== exp_vec() || rob_if.commit_valid !== 1'b0 || rob_if.rob_count !== 4'd2) begin
            n_fail++;
            $display("FAIL edge_cdb_nonbusy got=%h exp=%h", obs_vec(), exp_vec());
        end
        cyc(1'b0, 4'h0, 1'b1, 0, 16'h1234);
        cyc(1'b0, 4'h0, 1'b1, 0, 16'h5678);
        n_tests++;
        if (rob_if.commit_valid !== 1'b1 || rob_if.commit_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL edge_dup_cdb cv=%b data=%h exp 1/1234",
                     rob_if.commit_valid, rob_if.commit_data);
        end
        // Allocate and CDB to the same tag in one cycle: allocation wins.
        do_reset(1);
        cyc(1'b1, 4'h7, 1'b1, 0, 16'hDEAD);
        idle();
        idle();
        n_tests++;
        if (rob_if.commit_valid !== 1'b0 || rob_if.rob_count !== 4'd1) begin
            n_fail++;
            $display("FAIL edge_alloc_cdb_same cv=%b count=%0d exp 0/1",
                     rob_if.commit_valid, rob_if.rob_count);
        end
        // Reset mid-stream with four busy entries.
        do_reset(1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'(i), 1'b0, 0, 16'h0);
        cyc(1'b0, 4'h0, 1'b1, 0, 16'h4444);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            cyc(1'b0, 4'h0, 1'b1, t % 4, 16'h9999);
            n_tests++;
            if (rob_if.commit_valid !== 1'b0 || rob_if.rob_count !== 4'd0) begin
                n_fail++;
                $display("FAIL edge_mid_reset%0d cv=%b count=%0d exp 0/0", t,
                         rob_if.commit_valid, rob_if.rob_count);
            end
        end
    endtask

    task automatic test_random();
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            cyc($urandom_range(0, 99) < 55, 4'($urandom), $urandom_range(0, 99) < 60,
                $urandom_range(0, DEPTH - 1), 16'($urandom));
            rst = 1'b0;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_out_of_order();
        test_full();
        test_simultaneous();
        test_wrap();
        test_edge_cases();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
